// File: rtl/bcharger_pkg.sv
// Shared types and constants for the bcharger phase FSM and its supervisor.
package bcharger_pkg;

    typedef enum logic [1:0] {OFF, START, RUN, FAULT} sup_state_t;

    typedef enum logic [1:0] {F_NONE, F_TMO, F_TEMP, F_PHASE} fault_code_t;

    // Bit positions of the phase outputs when packed as {done, vconst, fast, trkl}
    localparam int PH_TRKL   = 0;
    localparam int PH_FAST   = 1;
    localparam int PH_VCONST = 2;
    localparam int PH_DONE   = 3;
    localparam int PH_N      = 4;

    function automatic logic is_onehot4(input logic [PH_N-1:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/bcharger_deb.sv
// Single-input comparator debouncer: output follows raw only after DEB_LEN
// consecutive differing samples; clr forces output and counter to zero.
module bcharger_deb #(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic raw,
    output logic q
);

    localparam int CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_LEN - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (raw == q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            q   <= raw;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcharger_supervisor.sv
// Supervisor for the bcharger phase FSM: debounces comparators, gates the
// charger via reset/enable, runs a per-phase safety timer and latches faults.
module bcharger_supervisor
    import bcharger_pkg::*;
#(
    parameter int DEB_LEN  = 4,
    parameter int TW       = 16,
    parameter int TRKL_TMO = 1000,
    parameter int FAST_TMO = 10000,
    parameter int CV_TMO   = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       temp_ok,
    input  logic       fault_clr,
    input  logic       cmp_vtrkl,
    input  logic       cmp_vterm,
    input  logic       cmp_iterm,
    input  logic       cmp_vrchrg,
    input  logic       ph_trkl,
    input  logic       ph_fast,
    input  logic       ph_vconst,
    input  logic       ph_done,
    output logic       vtrkl,
    output logic       vterm,
    output logic       iterm,
    output logic       vrchrg,
    output logic       chg_rst,
    output logic       chg_en,
    output logic       fault,
    output logic [1:0] fault_code,
    output sup_state_t dbg_state
);

    localparam longint TMAX = (64'd1 << TW) - 1;

    if ((TRKL_TMO > TMAX) || (FAST_TMO > TMAX) || (CV_TMO > TMAX)
        || (TRKL_TMO < 1) || (FAST_TMO < 1) || (CV_TMO < 1)) begin : g_tmo_check
        $error("bcharger_supervisor: timeout does not fit in TW-bit timer");
    end

    localparam logic [TW-1:0] TRKL_LIM = TW'(TRKL_TMO - 1);
    localparam logic [TW-1:0] FAST_LIM = TW'(FAST_TMO - 1);
    localparam logic [TW-1:0] CV_LIM   = TW'(CV_TMO - 1);

    sup_state_t      state, state_n;
    fault_code_t     code_q, code_n;
    logic [TW-1:0]   timer, timer_n, tmo_lim;
    logic [PH_N-1:0] ph_in, ph_q;
    logic            ph_chg, tmo_hit, deb_clr;

    assign ph_in  = {ph_done, ph_vconst, ph_fast, ph_trkl};
    assign ph_chg = (ph_in != ph_q);

    always_comb begin
        tmo_lim = '1;
        if (ph_in[PH_TRKL])        tmo_lim = TRKL_LIM;
        else if (ph_in[PH_FAST])   tmo_lim = FAST_LIM;
        else if (ph_in[PH_VCONST]) tmo_lim = CV_LIM;
    end

    assign tmo_hit = !ph_chg && !ph_in[PH_DONE] && (timer == tmo_lim);

    always_comb begin
        state_n = state;
        code_n  = code_q;
        timer_n = '0;
        unique case (state)
            OFF:   if (en && temp_ok) state_n = START;
            START: state_n = RUN;
            RUN: begin
                if (!temp_ok) begin
                    state_n = FAULT;
                    code_n  = F_TEMP;
                end else if (!is_onehot4(ph_in)) begin
                    state_n = FAULT;
                    code_n  = F_PHASE;
                end else if (tmo_hit) begin
                    state_n = FAULT;
                    code_n  = F_TMO;
                end else if (!en) begin
                    state_n = OFF;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_n = OFF;
                    code_n  = F_NONE;
                end
            end
            default: state_n = OFF;
        endcase
        // Done phase saturates instead of wrapping so it can never alias a limit
        if (state == RUN && state_n == RUN) begin
            if (ph_chg)                                timer_n = '0;
            else if (ph_in[PH_DONE] && (timer == '1))  timer_n = timer;
            else                                       timer_n = timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= OFF;
            code_q  <= F_NONE;
            timer   <= '0;
            ph_q    <= '0;
            chg_rst <= 1'b1;
            chg_en  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_n;
            code_q  <= code_n;
            timer   <= timer_n;
            ph_q    <= ph_in;
            chg_rst <= (state_n != RUN);
            chg_en  <= (state_n == RUN);
            fault   <= (state_n == FAULT);
        end
    end

    assign fault_code = code_q;
    assign dbg_state  = state;

    // Clear on the leaving edge too, so qualified outputs drop together with chg_en
    assign deb_clr = (state != RUN) || (state_n != RUN);

    bcharger_deb #(.DEB_LEN(DEB_LEN)) u_deb_vtrkl (
        .clk(clk), .reset(reset), .clr(deb_clr), .raw(cmp_vtrkl), .q(vtrkl));
    bcharger_deb #(.DEB_LEN(DEB_LEN)) u_deb_vterm (
        .clk(clk), .reset(reset), .clr(deb_clr), .raw(cmp_vterm), .q(vterm));
    bcharger_deb #(.DEB_LEN(DEB_LEN)) u_deb_iterm (
        .clk(clk), .reset(reset), .clr(deb_clr), .raw(cmp_iterm), .q(iterm));
    bcharger_deb #(.DEB_LEN(DEB_LEN)) u_deb_vrchrg (
        .clk(clk), .reset(reset), .clr(deb_clr), .raw(cmp_vrchrg), .q(vrchrg));

endmodule

// File: tb/tb_bcharger_supervisor.sv
// Directed bench for bcharger_supervisor with small timeouts so every phase limit is reachable.
module tb_bcharger_supervisor;
  import bcharger_pkg::*;

  localparam int DEB_LEN  = 4;
  localparam int TW       = 5;
  localparam int TRKL_TMO = 8;
  localparam int FAST_TMO = 12;
  localparam int CV_TMO   = 10;

  logic clk = 1'b0;
  logic reset, en, temp_ok, fault_clr;
  logic cmp_vtrkl, cmp_vterm, cmp_iterm, cmp_vrchrg;
  logic ph_trkl, ph_fast, ph_vconst, ph_done;
  logic vtrkl, vterm, iterm, vrchrg, chg_rst, chg_en, fault;
  logic [1:0] fault_code;
  sup_state_t dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  bcharger_supervisor #(
    .DEB_LEN(DEB_LEN), .TW(TW), .TRKL_TMO(TRKL_TMO),
    .FAST_TMO(FAST_TMO), .CV_TMO(CV_TMO)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .temp_ok(temp_ok), .fault_clr(fault_clr),
    .cmp_vtrkl(cmp_vtrkl), .cmp_vterm(cmp_vterm), .cmp_iterm(cmp_iterm),
    .cmp_vrchrg(cmp_vrchrg), .ph_trkl(ph_trkl), .ph_fast(ph_fast),
    .ph_vconst(ph_vconst), .ph_done(ph_done), .vtrkl(vtrkl), .vterm(vterm),
    .iterm(iterm), .vrchrg(vrchrg), .chg_rst(chg_rst), .chg_en(chg_en),
    .fault(fault), .fault_code(fault_code), .dbg_state(dbg_state)
  );

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ph(input logic t, input logic f, input logic v, input logic d);
    ph_trkl = t; ph_fast = f; ph_vconst = v; ph_done = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input sup_state_t st, input logic rst_e,
                          input logic en_e, input logic flt_e, input logic [1:0] code_e);
    chk({tag, "_state"}, 32'(dbg_state), 32'(st));
    chk({tag, "_chg_rst"}, 32'(chg_rst), 32'(rst_e));
    chk({tag, "_chg_en"}, 32'(chg_en), 32'(en_e));
    chk({tag, "_fault"}, 32'(fault), 32'(flt_e));
    chk({tag, "_code"}, 32'(fault_code), 32'(code_e));
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; temp_ok = 1'b0; fault_clr = 1'b0;
    cmp_vtrkl = 1'b0; cmp_vterm = 1'b0; cmp_iterm = 1'b0; cmp_vrchrg = 1'b0;
    set_ph(1'b0, 1'b0, 1'b0, 1'b1);
    step(2);
    reset = 1'b0;
    chk_ctrl("reset", OFF, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("reset_quals", 32'({vtrkl, vterm, iterm, vrchrg}), 32'd0);

    // start-up through START into RUN in done phase
    en = 1'b1; temp_ok = 1'b1;
    step(1);
    chk_ctrl("start", START, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1);
    chk_ctrl("run", RUN, 1'b0, 1'b1, 1'b0, 2'd0);

    // debounce: 3-cycle glitch rejected, 4-cycle level accepted on the 4th edge
    cmp_vtrkl = 1'b1;
    step(3);
    chk("deb_glitch3", 32'(vtrkl), 32'd0);
    cmp_vtrkl = 1'b0;
    step(1);
    chk("deb_glitch_end", 32'(vtrkl), 32'd0);
    cmp_vtrkl = 1'b1; cmp_vterm = 1'b1;
    step(3);
    chk("deb_edge3", 32'(vtrkl), 32'd0);
    step(1);
    chk("deb_edge4", 32'({vtrkl, vterm}), 32'b11);
    chk("deb_iterm_quiet", 32'(iterm), 32'd0);

    // reset mid-RUN overrides everything on the next edge
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_ctrl("midrst", OFF, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("midrst_quals", 32'({vtrkl, vterm, iterm, vrchrg}), 32'd0);
    cmp_vtrkl = 1'b0; cmp_vterm = 1'b0;

    // trickle timeout: no fault after 7 RUN edges, fault on the 8th
    set_ph(1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    chk("trkl_run", 32'(dbg_state), 32'(RUN));
    step(TRKL_TMO - 1);
    chk_ctrl("trkl_7", RUN, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1);
    chk_ctrl("trkl_8", FAULT, 1'b1, 1'b0, 1'b1, 2'd1);
    en = 1'b0;
    step(1);
    chk_ctrl("fault_sticky", FAULT, 1'b1, 1'b0, 1'b1, 2'd1);
    clear_fault();
    chk_ctrl("fault_clr", OFF, 1'b1, 1'b0, 1'b0, 2'd0);

    // over-temperature in fast phase, clear, restart
    en = 1'b1;
    set_ph(1'b0, 1'b1, 1'b0, 1'b0);
    step(4);
    temp_ok = 1'b0;
    step(1);
    chk_ctrl("temp", FAULT, 1'b1, 1'b0, 1'b1, 2'd2);
    temp_ok = 1'b1;
    clear_fault();
    chk_ctrl("temp_clr", OFF, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1);
    chk("restart_start", 32'(dbg_state), 32'(START));
    step(1);
    chk_ctrl("restart_run", RUN, 1'b0, 1'b1, 1'b0, 2'd0);

    // two phases set -> PHASE; with temp_ok low as well -> TEMP wins
    ph_vconst = 1'b1;
    step(1);
    chk_ctrl("phase2", FAULT, 1'b1, 1'b0, 1'b1, 2'd3);
    ph_vconst = 1'b0;
    clear_fault();
    step(2);
    chk("prio_run", 32'(dbg_state), 32'(RUN));
    ph_vconst = 1'b1; temp_ok = 1'b0;
    step(1);
    chk_ctrl("prio", FAULT, 1'b1, 1'b0, 1'b1, 2'd2);
    ph_vconst = 1'b0; temp_ok = 1'b1;
    clear_fault();

    // trkl -> fast switch in trickle cycle 7 restarts timer; fast limit then applies
    set_ph(1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    step(6);
    set_ph(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    chk("switch_nofault", 32'(fault), 32'd0);
    step(FAST_TMO - 1);
    chk_ctrl("fast_11", RUN, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1);
    chk_ctrl("fast_12", FAULT, 1'b1, 1'b0, 1'b1, 2'd1);
    set_ph(1'b0, 1'b0, 1'b0, 1'b1);
    clear_fault();

    // done phase held past timer wrap: never faults
    step(2);
    step((1 << TW) + 10);
    chk_ctrl("done_long", RUN, 1'b0, 1'b1, 1'b0, 2'd0);

    // no phase set -> PHASE
    ph_done = 1'b0;
    step(1);
    chk_ctrl("phase0", FAULT, 1'b1, 1'b0, 1'b1, 2'd3);
    ph_done = 1'b1;
    clear_fault();

    // en dropped in RUN -> OFF with qualified outputs cleared on the same edge
    step(2);
    cmp_vrchrg = 1'b1;
    step(DEB_LEN);
    chk("vrchrg_on", 32'(vrchrg), 32'd1);
    en = 1'b0;
    step(1);
    chk_ctrl("en_off", OFF, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("en_off_quals", 32'({vtrkl, vterm, iterm, vrchrg}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
